// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, stable-count debouncer and edge detector
// producing a clean level, rise/fall pulses and a mode-selected event pulse.
module input_conditioner #(
    parameter int   CHANNELS    = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 4,
    parameter int   EDGE_MODE   = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] b,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] evt,
    output logic                any_evt
);
    localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync;
    logic [CHANNELS-1:0][CW-1:0]          cnt;
    logic [CHANNELS-1:0] s, diff, commit, rise_n, fall_n, evt_n;

    always_comb begin
        s      = '0;
        commit = '0;
        for (int i = 0; i < CHANNELS; i++) s[i] = sync[i][SYNC_STAGES-1];
        diff = s ^ b;
        for (int i = 0; i < CHANNELS; i++) commit[i] = diff[i] && cnt[i] == LAST;
        rise_n = commit & s;
        fall_n = commit & ~s;
        evt_n  = EDGE_MODE == 0 ? rise_n : EDGE_MODE == 1 ? fall_n : commit;
    end

    // A commit always flips b, and any agreement between s and b clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= {CHANNELS{{SYNC_STAGES{RESET_LEVEL}}}};
            cnt     <= '0;
            b       <= {CHANNELS{RESET_LEVEL}};
            rise    <= '0;
            fall    <= '0;
            evt     <= '0;
            any_evt <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], a[i]};
                cnt[i]  <= diff[i] && !commit[i] ? cnt[i] + 1'b1 : '0;
            end
            b       <= b ^ commit;
            rise    <= rise_n;
            fall    <= fall_n;
            evt     <= evt_n;
            any_evt <= |evt_n;
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: random and directed stimulus against a sample-history reference model,
// with one instance in both-edge mode and one in rise-only mode sharing the same inputs.
module tb_input_conditioner;
    localparam int   N  = 4;
    localparam int   S  = 2;
    localparam int   D  = 4;
    localparam int   HL = S + D;
    localparam logic RL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] a = '0;
    logic [N-1:0] b, rise, fall, evt, b0, rise0, fall0, evt0;
    logic any_evt, any_evt0;

    int tests = 0;
    int fails = 0;

    logic [HL-1:0] h [N];
    logic [N-1:0]  mb, mr, mf;

    always #1 clk = ~clk;

    input_conditioner #(.CHANNELS(N), .SYNC_STAGES(S), .DEBOUNCE(D), .EDGE_MODE(2), .RESET_LEVEL(RL)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .rise(rise), .fall(fall), .evt(evt), .any_evt(any_evt)
    );

    input_conditioner #(.CHANNELS(N), .SYNC_STAGES(S), .DEBOUNCE(D), .EDGE_MODE(0), .RESET_LEVEL(RL)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b0), .rise(rise0), .fall(fall0), .evt(evt0), .any_evt(any_evt0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // h[c][k] holds the input sampled k edges ago; the level flips once the D samples
    // that have reached the end of the synchroniser all disagree with it.
    task automatic model(input logic [N-1:0] av, input logic r);
        mr = '0;
        mf = '0;
        for (int c = 0; c < N; c++) begin
            if (r) begin
                h[c]  = {HL{RL}};
                mb[c] = RL;
            end else begin
                h[c] = {h[c][HL-2:0], av[c]};
                if (h[c][HL-1:S] == {D{~mb[c]}}) begin
                    mr[c] = ~mb[c];
                    mf[c] = mb[c];
                    mb[c] = ~mb[c];
                end
            end
        end
    endtask

    task automatic cmp_all();
        chk("b",        32'(b),        32'(mb));
        chk("rise",     32'(rise),     32'(mr));
        chk("fall",     32'(fall),     32'(mf));
        chk("evt",      32'(evt),      32'(mr | mf));
        chk("any_evt",  32'(any_evt),  32'(|(mr | mf)));
        chk("b_m0",     32'(b0),       32'(mb));
        chk("rise_m0",  32'(rise0),    32'(mr));
        chk("fall_m0",  32'(fall0),    32'(mf));
        chk("evt_m0",   32'(evt0),     32'(mr));
        chk("any_m0",   32'(any_evt0), 32'(|mr));
    endtask

    task automatic step(input int n);
        logic [N-1:0] av;
        logic         r;
        repeat (n) begin
            av = a;
            @(posedge clk);
            r = rst;
            #1;
            model(av, r);
            cmp_all();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        a   = 4'hf;
        rst = 1'b1;
        step(3);
        chk("rst_b",    32'(b),       32'h0);
        chk("rst_rise", 32'(rise),    32'h0);
        chk("rst_any",  32'(any_evt), 32'h0);
        rst = 1'b0;
        step(5);
        chk("rel_b_e5", 32'(b), 32'h0);
        step(1);
        chk("rel_b_e6",    32'(b),        32'hf);
        chk("rel_rise_e6", 32'(rise),     32'hf);
        chk("rel_evt_e6",  32'(evt),      32'hf);
        chk("rel_any_e6",  32'(any_evt),  32'h1);
        chk("rel_evt0_e6", 32'(evt0),     32'hf);
        step(1);
        chk("rel_rise_e7", 32'(rise),    32'h0);
        chk("rel_any_e7",  32'(any_evt), 32'h0);
        a = '0;
        step(12);
        a[0] = 1'b1;
        step(5);
        chk("ch0_b_e5", 32'(b[0]), 32'h0);
        step(1);
        chk("ch0_b_e6",    32'(b[0]),    32'h1);
        chk("ch0_rise_e6", 32'(rise[0]), 32'h1);
        step(1);
        chk("ch0_rise_e7", 32'(rise[0]), 32'h0);
        step(13);
        a[0] = 1'b0;
        step(20);
        a[1] = 1'b1;
        step(3);
        a[1] = 1'b0;
        step(12);
        chk("glitch_b1", 32'(b[1]), 32'h0);
        a[1] = 1'b1;
        step(4);
        a[1] = 1'b0;
        step(14);
        a[2] = 1'b1;
        step(3);
        a[2] = 1'b0;
        step(1);
        a[2] = 1'b1;
        step(5);
        chk("restart_b2_e5", 32'(b[2]), 32'h0);
        step(1);
        chk("restart_b2_e6", 32'(b[2]), 32'h1);
        step(4);
        a[2] = 1'b0;
        step(10);
        a = 4'b1001;
        step(6);
        chk("simul_evt0", 32'(evt0),     32'b1001);
        chk("simul_any0", 32'(any_evt0), 32'h1);
        step(4);
        a = '0;
        step(10);
        a[2] = 1'b1;
        step(4);
        #0.2 rst = 1'b1;
        step(2);
        chk("midrst_b2",   32'(b[2]),    32'h0);
        chk("midrst_rise", 32'(rise),    32'h0);
        rst = 1'b0;
        step(10);
        a = '0;
        step(10);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) a[c] = ~a[c];
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            step(1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel input conditioner that generalises the single-input, single-output clocked block used in the design: every raw asynchronous input passes through a synchroniser, a stable-count debouncer and an edge detector. Each channel produces a clean level, rise and fall pulses, and a mode-selected event pulse. The block sits between board-level inputs (buttons, switches, external strobes) and the synchronous logic in `top`.

## Interface
- `CHANNELS`, default 4: number of independent input channels, ≥1.
- `SYNC_STAGES`, default 2: synchroniser flop count per channel, ≥2.
- `DEBOUNCE`, default 4: consecutive cycles a synchronised value must differ from the current level before the level updates, ≥1.
- `EDGE_MODE`, default 2: event selection. 0 = rise, 1 = fall, 2 = both. Any other value behaves as 2.
- `RESET_LEVEL`, default 0: 1-bit reset value for the synchroniser flops and for `b`, applied to all channels.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a`  in  CHANNELS  raw asynchronous inputs, one bit per channel.
- `b`  out  CHANNELS  debounced, registered level per channel.
- `rise`  out  CHANNELS  1-cycle pulse when `b[i]` goes 0→1.
- `fall`  out  CHANNELS  1-cycle pulse when `b[i]` goes 1→0.
- `evt`  out  CHANNELS  1-cycle pulse selected per `EDGE_MODE`.
- `any_evt`  out  1  registered OR of the next-state `evt` bits; high in the same cycle as any `evt` bit.

## Operation
- Each channel is fully independent. There is no cross-channel state except `any_evt`.
- Synchroniser: a shift chain of `SYNC_STAGES` flops. `s[i]` is the last stage.
- Debouncer, one counter `cnt[i]` per channel. Counter width is max(1, $clog2(DEBOUNCE)).
  - IDLE (`s[i] == b[i]`): `cnt[i] <= 0`.
  - COUNT (`s[i] != b[i]`) with `cnt[i] < DEBOUNCE-1`: `cnt[i] <= cnt[i]+1`.
  - COMMIT (`s[i] != b[i]`) with `cnt[i] == DEBOUNCE-1`: `b[i] <= s[i]`, `cnt[i] <= 0`, and the edge pulse is asserted.
- Glitch rejection: if `s[i]` returns to `b[i]` before COMMIT, the counter clears, `b[i]` is unchanged and no pulse is generated.
- A glitch that resets the count restarts the full `DEBOUNCE` window. There is no partial credit.
- `rise[i]`, `fall[i]`, `evt[i]` and `any_evt` are registered. They are high for exactly the cycle after the COMMIT edge and low otherwise.
- `rise[i]` and `fall[i]` are never high together.
- With `DEBOUNCE == 1`, `b[i]` commits on the first edge at which `s[i] != b[i]`.
- The counter never exceeds `DEBOUNCE-1` and never wraps.

## Timing
- Reset (async assert, released synchronously by the user):
  - all synchroniser flops = `RESET_LEVEL`
  - `b` = `{CHANNELS{RESET_LEVEL}}`
  - `cnt` = 0
  - `rise`, `fall`, `evt`, `any_evt` = 0
- Reset mid-count aborts the count with no pulse.
- No pulse is generated on reset deassertion, even if `a` differs from `RESET_LEVEL`. That difference is debounced normally afterwards.
- Latency: let E1 be the first rising edge sampling a new stable `a[i]`. `b[i]` and the pulse update on edge E(`SYNC_STAGES`+`DEBOUNCE`). With defaults this is E6 (5 full cycles after E1).
- Minimum accepted pulse width on `a[i]`: `DEBOUNCE` cycles, once seen through the synchroniser. Shorter pulses are always rejected.
- Back-to-back toggles of `b[i]` are at least `DEBOUNCE` cycles apart.
- Simultaneous commits on several channels in the same cycle each produce their own pulses. `any_evt` is a single 1-cycle pulse.

## Test plan
- Reset: assert `rst` with `a=4'b1111` and `RESET_LEVEL=0`, then release. Required: `b=0` and no pulses during reset. Afterwards `b=4'b1111` on edge 6 after release, with `rise=4'b1111`, `evt=4'b1111` and `any_evt=1` for one cycle.
- Clean rise/fall on ch0 (clk period 2 ns, defaults):
  - `a[0]` 0→1 held 20 cycles. Required: `b[0]` rises on E6 and `rise[0]` is 1 cycle wide.
  - `a[0]` then 1→0. Required: `fall[0]` 1 cycle, `evt[0]` 1 cycle (`EDGE_MODE=2`).
- Glitch rejection: `a[1]` high for 3 cycles then low. Required: `b[1]` stays 0 and `rise`, `fall`, `evt` all stay 0. Then `a[1]` high for exactly 4 cycles. Required: `b[1]` goes 1 for 4 cycles and both `rise[1]` and `fall[1]` pulse once.
- Restart window: `a[2]` high 3 cycles, low 1 cycle, high 10 cycles. Required: `b[2]` rises 4+2 cycles after the final rising transition is sampled, not earlier.
- Mode and simultaneity: `EDGE_MODE=0`, channels 0 and 3 toggle in the same cycle. Required: `evt` pulses only on their rising commits and never on falling commits; `any_evt` is a single 1-cycle pulse per simultaneous commit.
- Reset mid-count: assert `rst` 2 cycles into a `DEBOUNCE=4` count on ch2. Required: `cnt` clears, `b[2]` equals `RESET_LEVEL`, and no pulse occurs.
